// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: decodes SPI command frames into register bank write/read
// transactions and streams read data back to the SPI byte transmitter.
module spi_reg_ctrl #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 16,
  localparam int ADDR_W     = $clog2(NUM_REGS),
  localparam int BYTES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_active,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_byte,
  output logic                  spi_wr_en,
  output logic [ADDR_W-1:0]     spi_addr_wr,
  output logic [DATA_WIDTH-1:0] data_wr_spi,
  output logic                  spi_rd_en,
  output logic [ADDR_W-1:0]     spi_addr_rd,
  input  logic [DATA_WIDTH-1:0] data_rd_spi,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam int CNT_W = $clog2(BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    RD_FETCH,
    RD_SEND,
    ERR
  } state_e;

  state_e                state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic                  tx_valid_q;
  logic                  spi_wr_en_q;
  logic [ADDR_W-1:0]     spi_addr_wr_q;
  logic [DATA_WIDTH-1:0] data_wr_spi_q;
  logic                  spi_rd_en_q;
  logic [ADDR_W-1:0]     spi_addr_rd_q;
  logic                  cmd_err_q;

  logic [DATA_WIDTH-1:0] wr_data_d;
  logic [6:0]            rsv_d;

  // Next write-data word (MSB byte first) and the reserved command field.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    wr_data_d = (wr_data_q << 8) | DATA_WIDTH'(rx_byte);
    rsv_d     = rx_byte[6:0] >> ADDR_W;
  end

  // Command FSM with registered strobes, addresses and transmit path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      wr_data_q     <= '0;
      tx_shift_q    <= '0;
      tx_valid_q    <= 1'b0;
      spi_wr_en_q   <= 1'b0;
      spi_addr_wr_q <= '0;
      data_wr_spi_q <= '0;
      spi_rd_en_q   <= 1'b0;
      spi_addr_rd_q <= '0;
      cmd_err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values;
      // pulse outputs default low here so each strobe lasts exactly one cycle.
      spi_wr_en_q <= 1'b0;
      spi_rd_en_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      if (!frame_active) begin
        // Frame end wins over everything, including a byte in the same cycle.
        state_q    <= IDLE;
        cnt_q      <= '0;
        wr_data_q  <= '0;
        tx_shift_q <= '0;
        tx_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_valid) begin
              if (rsv_d != 7'd0) begin
                cmd_err_q <= 1'b1;
                state_q   <= ERR;
              end else if (rx_byte[7]) begin
                addr_q    <= rx_byte[ADDR_W-1:0];
                cnt_q     <= '0;
                wr_data_q <= '0;
                state_q   <= WR_DATA;
              end else begin
                addr_q        <= rx_byte[ADDR_W-1:0];
                spi_rd_en_q   <= 1'b1;
                spi_addr_rd_q <= rx_byte[ADDR_W-1:0];
                state_q       <= RD_FETCH;
              end
            end
          end
          WR_DATA: begin
            if (rx_valid) begin
              wr_data_q <= wr_data_d;
              if (cnt_q == LAST_BYTE) begin
                spi_wr_en_q   <= 1'b1;
                spi_addr_wr_q <= addr_q;
                data_wr_spi_q <= wr_data_d;
                cnt_q         <= '0;
                state_q       <= IDLE;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          RD_FETCH: begin
            // Bank data is valid combinationally while spi_rd_en is high.
            tx_shift_q <= data_rd_spi;
            tx_valid_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= RD_SEND;
          end
          RD_SEND: begin
            if (tx_ready) begin
              tx_shift_q <= tx_shift_q << 8;
              if (cnt_q == LAST_BYTE) begin
                tx_valid_q <= 1'b0;
                cnt_q      <= '0;
                state_q    <= IDLE;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          ERR: begin
            // Hold here, ignoring bytes, until the frame ends.
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_byte     = tx_shift_q[DATA_WIDTH-1 -: 8];
  assign spi_wr_en   = spi_wr_en_q;
  assign spi_addr_wr = spi_addr_wr_q;
  assign data_wr_spi = data_wr_spi_q;
  assign spi_rd_en   = spi_rd_en_q;
  assign spi_addr_rd = spi_addr_rd_q;
  assign busy        = (state_q != IDLE);
  assign cmd_err     = cmd_err_q;

endmodule
